fwrisc_mem_arb: RTL and testbench

Parametrised single-port memory arbiter for fwrisc core configurations. It merges the core's instruction-fetch bus and data bus onto one valid/ready memory bus, so any fwrisc variant (RV32I, RV32IMC, ...) can attach to a single-ported RAM or bus bridge. It adds selectable arbitration priority, registered memory-side outputs and an optional bus-timeout with error reporting.

---
 rtl/fwrisc_mem_arb.sv | 182 ++++++++++++++++++
 tb/tb_fwrisc_mem_arb.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_mem_arb.sv
// ---------------------------------------------------------------------------
// fwrisc_mem_arb
//
// Merges the fwrisc instruction-fetch bus and data bus onto one single-ported
// valid/ready memory bus. Only one access is ever in flight. The memory-side
// outputs are registered, and an optional timeout can abort an access that
// the memory never completes.
//
// Handshake semantics (all three buses):
//   A requester raises *valid with its address/data stable and holds them
//   until it sees its one-cycle *ready completion pulse. On the memory side
//   the arbiter holds mvalid and every m* output stable until mready=1 is
//   sampled on a rising clock edge; that edge completes the access and
//   mrdata is captured on it.
//
// Parameters:
//   ADDR_WIDTH     width of iaddr/daddr/maddr (8..32)
//   DATA_PRIORITY  1: data wins a simultaneous request; 0: round-robin
//   TIMEOUT_CYCLES 0: wait forever; N>0: abort after N mvalid cycles without
//                  mready and report berr
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   iaddr/ivalid          fetch request; iready/idata fetch completion
//   daddr/dwdata/dwstb/dwrite/dvalid   data request; dready/drdata completion
//   maddr/mwdata/mwstb/mwrite/mvalid   registered memory request
//   mrdata/mready         memory read data and completion
//   berr                  pulses with iready/dready when the access timed out
//   dbg_state             current FSM state (IDLE=0, BUSY_I=1, BUSY_D=2,
//                         RESP_I=3, RESP_D=4)
// ---------------------------------------------------------------------------
module fwrisc_mem_arb #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_PRIORITY  = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic                  ivalid,
  output logic                  iready,
  output logic [31:0]           idata,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [31:0]           dwdata,
  input  logic [3:0]            dwstb,
  input  logic                  dwrite,
  input  logic                  dvalid,
  output logic                  dready,
  output logic [31:0]           drdata,
  output logic [ADDR_WIDTH-1:0] maddr,
  output logic [31:0]           mwdata,
  output logic [3:0]            mwstb,
  output logic                  mwrite,
  output logic                  mvalid,
  input  logic [31:0]           mrdata,
  input  logic                  mready,
  output logic                  berr,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t state;
  logic   last_grant_d;   // 0 = last grant went to fetch, 1 = to data
  logic   grant_d;
  logic   busy;
  logic   timeout_hit;

  assign dbg_state = state;
  assign busy      = (state == BUSY_I) || (state == BUSY_D);

  // Arbitration decision, only consulted in IDLE. Under round-robin the
  // side that did not win last time takes a tie; since last_grant resets to
  // fetch, the first tie after reset goes to data.
  always_comb begin
    grant_d = 1'b0;
    if (dvalid && !ivalid) begin
      grant_d = 1'b1;
    end else if (dvalid && ivalid) begin
      grant_d = (DATA_PRIORITY != 0) ? 1'b1 : !last_grant_d;
    end
  end

  // Timeout counter: zero outside BUSY so every access starts from 0. The
  // abort fires on the BUSY cycle that would bring the count to N, giving
  // exactly N cycles of mvalid; an mready on that same cycle wins.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] tcnt;

    always_ff @(posedge clock) begin
      if (reset) begin
        tcnt <= '0;
      end else if (busy) begin
        if (!mready) tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end

    assign timeout_hit = busy && !mready && (tcnt == LAST);
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      last_grant_d <= 1'b0;
      mvalid       <= 1'b0;
      mwrite       <= 1'b0;
      maddr        <= '0;
      mwdata       <= '0;
      mwstb        <= '0;
      iready       <= 1'b0;
      dready       <= 1'b0;
      berr         <= 1'b0;
      idata        <= '0;
      drdata       <= '0;
    end else begin
      // Completion strobes are single-cycle by default.
      iready <= 1'b0;
      dready <= 1'b0;
      berr   <= 1'b0;

      case (state)
        IDLE: begin
          if (ivalid || dvalid) begin
            mvalid <= 1'b1;
            if (grant_d) begin
              maddr        <= daddr;
              mwdata       <= dwdata;
              mwstb        <= dwstb;
              mwrite       <= dwrite;
              last_grant_d <= 1'b1;
              state        <= BUSY_D;
            end else begin
              // Fetches are always reads with no strobes.
              maddr        <= iaddr;
              mwdata       <= '0;
              mwstb        <= 4'h0;
              mwrite       <= 1'b0;
              last_grant_d <= 1'b0;
              state        <= BUSY_I;
            end
          end
        end

        BUSY_I, BUSY_D: begin
          if (mready || timeout_hit) begin
            mvalid <= 1'b0;
            // An aborted access returns all-ones and flags berr.
            berr   <= !mready;
            if (state == BUSY_I) begin
              idata  <= mready ? mrdata : 32'hFFFF_FFFF;
              iready <= 1'b1;
              state  <= RESP_I;
            end else begin
              drdata <= mready ? mrdata : 32'hFFFF_FFFF;
              dready <= 1'b1;
              state  <= RESP_D;
            end
          end
        end

        // The ready pulse is visible during RESP; no arbitration here so
        // the requester's still-high valid is not granted a second time.
        RESP_I, RESP_D: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_fwrisc_mem_arb
//
// Three arbiter instances share clock and reset:
//   inst0: DATA_PRIORITY=1, no timeout
//   inst1: DATA_PRIORITY=0 (round-robin), no timeout
//   inst2: DATA_PRIORITY=1, TIMEOUT_CYCLES=4
// A core driver presents queued requests, a memory model answers each
// access after a programmed number of wait cycles, and a monitor checks the
// memory bus and the completion pulses against expected queues filled by
// the directed stimulus.
// ---------------------------------------------------------------------------
module tb_fwrisc_mem_arb;

  localparam int NI = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] iaddr [NI];
  logic [31:0] idata [NI];
  logic [31:0] daddr [NI];
  logic [31:0] dwdata[NI];
  logic [31:0] drdata[NI];
  logic [31:0] maddr [NI];
  logic [31:0] mwdata[NI];
  logic [31:0] mrdata[NI];
  logic [3:0]  dwstb [NI];
  logic [3:0]  mwstb [NI];
  logic        ivalid[NI];
  logic        iready[NI];
  logic        dwrite[NI];
  logic        dvalid[NI];
  logic        dready[NI];
  logic        mwrite[NI];
  logic        mvalid[NI];
  logic        mready[NI];
  logic        berr  [NI];
  logic [2:0]  dbg_state[NI];

  fwrisc_mem_arb #(.ADDR_WIDTH(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(0)) u_dut0 (
    .clock(clk), .reset(reset),
    .iaddr(iaddr[0]), .ivalid(ivalid[0]), .iready(iready[0]), .idata(idata[0]),
    .daddr(daddr[0]), .dwdata(dwdata[0]), .dwstb(dwstb[0]), .dwrite(dwrite[0]),
    .dvalid(dvalid[0]), .dready(dready[0]), .drdata(drdata[0]),
    .maddr(maddr[0]), .mwdata(mwdata[0]), .mwstb(mwstb[0]), .mwrite(mwrite[0]),
    .mvalid(mvalid[0]), .mrdata(mrdata[0]), .mready(mready[0]), .berr(berr[0]),
    .dbg_state(dbg_state[0])
  );

  fwrisc_mem_arb #(.ADDR_WIDTH(32), .DATA_PRIORITY(0), .TIMEOUT_CYCLES(0)) u_dut1 (
    .clock(clk), .reset(reset),
    .iaddr(iaddr[1]), .ivalid(ivalid[1]), .iready(iready[1]), .idata(idata[1]),
    .daddr(daddr[1]), .dwdata(dwdata[1]), .dwstb(dwstb[1]), .dwrite(dwrite[1]),
    .dvalid(dvalid[1]), .dready(dready[1]), .drdata(drdata[1]),
    .maddr(maddr[1]), .mwdata(mwdata[1]), .mwstb(mwstb[1]), .mwrite(mwrite[1]),
    .mvalid(mvalid[1]), .mrdata(mrdata[1]), .mready(mready[1]), .berr(berr[1]),
    .dbg_state(dbg_state[1])
  );

  fwrisc_mem_arb #(.ADDR_WIDTH(32), .DATA_PRIORITY(1), .TIMEOUT_CYCLES(4)) u_dut2 (
    .clock(clk), .reset(reset),
    .iaddr(iaddr[2]), .ivalid(ivalid[2]), .iready(iready[2]), .idata(idata[2]),
    .daddr(daddr[2]), .dwdata(dwdata[2]), .dwstb(dwstb[2]), .dwrite(dwrite[2]),
    .dvalid(dvalid[2]), .dready(dready[2]), .drdata(drdata[2]),
    .maddr(maddr[2]), .mwdata(mwdata[2]), .mwstb(mwstb[2]), .mwrite(mwrite[2]),
    .mvalid(mvalid[2]), .mrdata(mrdata[2]), .mready(mready[2]), .berr(berr[2]),
    .dbg_state(dbg_state[2])
  );

  // ---------------- queues ----------------
  logic [31:0] ireq_q [NI][$];   // fetch addresses
  logic [68:0] dreq_q [NI][$];   // {addr, wdata, wstb, write}
  logic [39:0] mresp_q[NI][$];   // {wait cycles, read data}
  logic [76:0] exp_m_q[NI][$];   // {addr, wdata, wstb, write, mvalid cycles}
  logic [34:0] exp_r_q[NI][$];   // {side(1=data), data care, data, berr}

  int n_vec = 0;
  int n_err = 0;
  int last_rdy_cyc[NI];

  task automatic check(input string name, input int n,
                       input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %h expected %h (t=%0t)", name, n, act, exp, $time);
    end
  endtask

  // ---------------- core driver ----------------
  initial begin
    for (int n = 0; n < NI; n++) begin
      ivalid[n] = 1'b0; dvalid[n] = 1'b0; iaddr[n] = '0; daddr[n] = '0;
      dwdata[n] = '0; dwstb[n] = '0; dwrite[n] = 1'b0;
    end
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < NI; n++) begin
        if (reset) begin
          ireq_q[n].delete();
          dreq_q[n].delete();
        end else begin
          if (ivalid[n] && iready[n]) void'(ireq_q[n].pop_front());
          if (dvalid[n] && dready[n]) void'(dreq_q[n].pop_front());
        end
        ivalid[n] = (ireq_q[n].size() != 0);
        if (ivalid[n]) iaddr[n] = ireq_q[n][0];
        dvalid[n] = (dreq_q[n].size() != 0);
        if (dvalid[n]) {daddr[n], dwdata[n], dwstb[n], dwrite[n]} = dreq_q[n][0];
      end
    end
  end

  // ---------------- memory model ----------------
  logic        mact [NI];
  int          mcnt [NI];
  logic [7:0]  mwait[NI];
  logic [31:0] mdat [NI];

  initial begin
    for (int n = 0; n < NI; n++) begin
      mready[n] = 1'b0; mrdata[n] = '0; mact[n] = 1'b0; mcnt[n] = 0;
      mwait[n] = '0; mdat[n] = '0;
    end
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < NI; n++) begin
        mready[n] = 1'b0;
        mrdata[n] = $urandom;   // junk unless mready
        if (!reset && mvalid[n]) begin
          if (!mact[n]) begin
            mact[n] = 1'b1;
            mcnt[n] = 0;
            if (mresp_q[n].size() != 0) {mwait[n], mdat[n]} = mresp_q[n].pop_front();
            else begin mwait[n] = 8'd255; mdat[n] = '0; end
          end
          if (mcnt[n] == int'(mwait[n])) begin
            mready[n] = 1'b1;
            mrdata[n] = mdat[n];
          end else begin
            mcnt[n]++;
          end
        end else begin
          mact[n] = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic prev_mv[NI];
  int   mdur[NI];

  initial begin
    for (int n = 0; n < NI; n++) begin prev_mv[n] = 1'b0; mdur[n] = 0; last_rdy_cyc[n] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int n = 0; n < NI; n++) begin
        if (reset) begin
          prev_mv[n] = 1'b0;
          mdur[n]    = 0;
        end else begin
          if (mvalid[n]) begin
            if (exp_m_q[n].size() == 0) begin
              check("unexpected_mvalid", n, 80'(mvalid[n]), 80'(0));
            end else begin
              check("mbus", n, 80'({maddr[n], mwdata[n], mwstb[n], mwrite[n]}),
                    80'(exp_m_q[n][0][76:8]));
            end
            mdur[n]++;
          end
          if (prev_mv[n] && !mvalid[n]) begin
            if (exp_m_q[n].size() != 0) begin
              check("mvalid_cycles", n, 80'(mdur[n]), 80'(exp_m_q[n][0][7:0]));
              void'(exp_m_q[n].pop_front());
            end
            check("ready_after_mvalid", n, 80'(iready[n] | dready[n]), 80'(1));
            mdur[n] = 0;
          end
          if (iready[n] || dready[n]) begin
            logic [34:0] e;
            last_rdy_cyc[n] = cyc;
            check("ready_exclusive", n, 80'(iready[n] & dready[n]), 80'(0));
            if (exp_r_q[n].size() == 0) begin
              check("unexpected_ready", n, 80'({iready[n], dready[n]}), 80'(0));
            end else begin
              e = exp_r_q[n].pop_front();
              check("resp_side", n, 80'(dready[n]), 80'(e[34]));
              if (e[33]) check("resp_data", n, 80'(dready[n] ? drdata[n] : idata[n]), 80'(e[32:1]));
              check("resp_berr", n, 80'(berr[n]), 80'(e[0]));
            end
          end
          prev_mv[n] = mvalid[n];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_i(input int n, input logic [31:0] a);
    ireq_q[n].push_back(a);
  endtask

  task automatic push_d(input int n, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] stb, input logic wr);
    dreq_q[n].push_back({a, wd, stb, wr});
  endtask

  task automatic push_mem(input int n, input logic [7:0] w, input logic [31:0] d);
    mresp_q[n].push_back({w, d});
  endtask

  task automatic add_m(input int n, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] stb, input logic wr, input logic [7:0] dur);
    exp_m_q[n].push_back({a, wd, stb, wr, dur});
  endtask

  task automatic add_r(input int n, input logic side_d, input logic care,
                       input logic [31:0] d, input logic be);
    exp_r_q[n].push_back({side_d, care, d, be});
  endtask

  task automatic drain(input int n);
    int k;
    for (k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (ireq_q[n].size() == 0 && dreq_q[n].size() == 0 && exp_m_q[n].size() == 0 &&
          exp_r_q[n].size() == 0 && dbg_state[n] == 3'd0) break;
    end
    check("drain_timeout", n, 80'(k >= 400), 80'(0));
    if (k >= 400) begin
      ireq_q[n].delete(); dreq_q[n].delete(); mresp_q[n].delete();
      exp_m_q[n].delete(); exp_r_q[n].delete();
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int c_start;
    int k;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    for (int n = 0; n < NI; n++) begin
      check("rst_ctrl", n, 80'({mvalid[n], mwrite[n], iready[n], dready[n], berr[n], mwstb[n], dbg_state[n]}), 80'(0));
      check("rst_maddr", n, 80'(maddr[n]), 80'(0));
      check("rst_mwdata", n, 80'(mwdata[n]), 80'(0));
      check("rst_idata", n, 80'(idata[n]), 80'(0));
      check("rst_drdata", n, 80'(drdata[n]), 80'(0));
    end
    reset = 1'b0;

    // Single fetch: mready on the second mvalid cycle, iready 3 cycles after
    // ivalid first appears.
    push_mem(0, 8'd1, 32'h0000_0013);
    add_m(0, 32'h100, 32'h0, 4'h0, 1'b0, 8'd2);
    add_r(0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
    push_i(0, 32'h100);
    c_start = cyc;
    drain(0);
    // ivalid appears after edge c_start+1 (cycle 0); iready is seen after edge c_start+4.
    check("fetch_latency", 0, 80'(last_rdy_cyc[0] - c_start), 80'(4));

    // Data write with 3 wait cycles: 4 stable mvalid cycles, one dready.
    push_mem(0, 8'd3, 32'h5555_AAAA);
    add_m(0, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1, 8'd4);
    add_r(0, 1'b1, 1'b0, 32'h0, 1'b0);
    push_d(0, 32'h2000, 32'hDEAD_BEEF, 4'b0011, 1'b1);
    drain(0);

    // Ties with data priority: data first, then fetch, twice.
    push_mem(0, 8'd0, 32'hCAFE_0001);
    push_mem(0, 8'd0, 32'h00A0_0093);
    add_m(0, 32'h300, 32'h0, 4'h0, 1'b0, 8'd1);
    add_m(0, 32'h104, 32'h0, 4'h0, 1'b0, 8'd1);
    add_r(0, 1'b1, 1'b1, 32'hCAFE_0001, 1'b0);
    add_r(0, 1'b0, 1'b1, 32'h00A0_0093, 1'b0);
    push_i(0, 32'h104);
    push_d(0, 32'h300, 32'h0, 4'h0, 1'b0);
    drain(0);
    push_mem(0, 8'd1, 32'h0000_0000);
    push_mem(0, 8'd1, 32'h0010_8093);
    add_m(0, 32'h304, 32'h1234_5678, 4'hF, 1'b1, 8'd2);
    add_m(0, 32'h108, 32'h0, 4'h0, 1'b0, 8'd2);
    add_r(0, 1'b1, 1'b0, 32'h0, 1'b0);
    add_r(0, 1'b0, 1'b1, 32'h0010_8093, 1'b0);
    push_i(0, 32'h108);
    push_d(0, 32'h304, 32'h1234_5678, 4'hF, 1'b1);
    drain(0);

    // Round-robin with both sides continuously requesting: D, I, D, I.
    push_mem(1, 8'd0, 32'h1111_0400);
    push_mem(1, 8'd0, 32'h2222_0200);
    push_mem(1, 8'd2, 32'h3333_0404);
    push_mem(1, 8'd0, 32'h4444_0204);
    add_m(1, 32'h400, 32'h0, 4'h0, 1'b0, 8'd1);
    add_m(1, 32'h200, 32'h0, 4'h0, 1'b0, 8'd1);
    add_m(1, 32'h404, 32'h0, 4'h0, 1'b0, 8'd3);
    add_m(1, 32'h204, 32'h0, 4'h0, 1'b0, 8'd1);
    add_r(1, 1'b1, 1'b1, 32'h1111_0400, 1'b0);
    add_r(1, 1'b0, 1'b1, 32'h2222_0200, 1'b0);
    add_r(1, 1'b1, 1'b1, 32'h3333_0404, 1'b0);
    add_r(1, 1'b0, 1'b1, 32'h4444_0204, 1'b0);
    push_i(1, 32'h200);
    push_i(1, 32'h204);
    push_d(1, 32'h400, 32'h0, 4'h0, 1'b0);
    push_d(1, 32'h404, 32'h0, 4'h0, 1'b0);
    drain(1);

    // Timeout N=4: unanswered data read aborts after 4 mvalid cycles.
    push_mem(2, 8'd200, 32'h0);
    add_m(2, 32'h500, 32'h0, 4'h0, 1'b0, 8'd4);
    add_r(2, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    push_d(2, 32'h500, 32'h0, 4'h0, 1'b0);
    drain(2);
    // mready on exactly the 4th cycle completes normally.
    push_mem(2, 8'd3, 32'h0BAD_F00D);
    add_m(2, 32'h504, 32'h0, 4'h0, 1'b0, 8'd4);
    add_r(2, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b0);
    push_d(2, 32'h504, 32'h0, 4'h0, 1'b0);
    drain(2);
    // Unanswered fetch also times out.
    push_mem(2, 8'd200, 32'h0);
    add_m(2, 32'h600, 32'h0, 4'h0, 1'b0, 8'd4);
    add_r(2, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
    push_i(2, 32'h600);
    drain(2);

    // Reset in the middle of a data access that never completes.
    push_mem(0, 8'd200, 32'h0);
    add_m(0, 32'h2100, 32'h0, 4'h0, 1'b0, 8'd0);
    push_d(0, 32'h2100, 32'h0, 4'h0, 1'b0);
    for (k = 0; k < 20 && !mvalid[0]; k++) begin @(posedge clk); #2; end
    repeat (10) @(posedge clk);
    #2;
    check("no_timeout_wait", 0, 80'(mvalid[0]), 80'(1));
    reset = 1'b1;
    @(posedge clk); #2;
    check("rst_mid_mvalid", 0, 80'(mvalid[0]), 80'(0));
    check("rst_mid_ready", 0, 80'({iready[0], dready[0]}), 80'(0));
    check("rst_mid_berr", 0, 80'(berr[0]), 80'(0));
    for (int n = 0; n < NI; n++) begin
      exp_m_q[n].delete(); exp_r_q[n].delete(); mresp_q[n].delete();
    end
    reset = 1'b0;

    // Service resumes normally after reset (tie -> data first).
    push_mem(0, 8'd2, 32'h7777_0001);
    push_mem(0, 8'd0, 32'h00C0_0113);
    add_m(0, 32'h2200, 32'h0, 4'h0, 1'b0, 8'd3);
    add_m(0, 32'h180, 32'h0, 4'h0, 1'b0, 8'd1);
    add_r(0, 1'b1, 1'b1, 32'h7777_0001, 1'b0);
    add_r(0, 1'b0, 1'b1, 32'h00C0_0113, 1'b0);
    push_i(0, 32'h180);
    push_d(0, 32'h2200, 32'h0, 4'h0, 1'b0);
    drain(0);

    // Read data holds its value after the ready pulse.
    repeat (3) @(posedge clk);
    #2;
    check("idata_hold", 0, 80'(idata[0]), 80'(32'h00C0_0113));
    check("drdata_hold", 0, 80'(drdata[0]), 80'(32'h7777_0001));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
